// File: rtl/ladybird_alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU with a one-entry result register.
// SLT/SLTU are resolved locally; every other op captures the external ALU result.

package ladybird_config;
    parameter int unsigned XLEN = 32;
endpackage

module ladybird_alu_arbiter #(
    parameter int unsigned XLEN = ladybird_config::XLEN
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][2:0]      req_op,
    input  logic [1:0]           req_alt,
    input  logic [1:0][XLEN-1:0] req_src1,
    input  logic [1:0][XLEN-1:0] req_src2,
    output logic [2:0]           alu_operation,
    output logic                 alu_alternate,
    output logic [XLEN-1:0]      alu_src1,
    output logic [XLEN-1:0]      alu_src2,
    input  logic [XLEN-1:0]      alu_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_q,
    output logic                 rsp_id
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e            state_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              rsp_id_q;
    logic              ptr_q;

    logic              gnt_en;
    logic              gnt_any;
    logic              gnt_id;
    logic              slt_res;
    logic              sltu_res;
    logic [XLEN-1:0]   result;

    // Grant only looks at valids, pointer, state and rsp_ready so ready never waits on operands.
    always_comb begin
        gnt_en    = nrst && ((state_q == StEmpty) || rsp_ready);
        gnt_any   = gnt_en && (req_valid != 2'b00);
        gnt_id    = 1'b0;
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~ptr_q;
            default: gnt_id = 1'b0;
        endcase
        req_ready = 2'b00;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        alu_operation = 3'b000;
        alu_alternate = 1'b0;
        alu_src1      = '0;
        alu_src2      = '0;
        if (gnt_any) begin
            alu_operation = req_op[gnt_id];
            alu_alternate = req_alt[gnt_id];
            alu_src1      = req_src1[gnt_id];
            alu_src2      = req_src2[gnt_id];
        end
    end

    always_comb begin
        slt_res  = $signed(alu_src1) < $signed(alu_src2);
        sltu_res = alu_src1 < alu_src2;
        case (alu_operation)
            3'b010:  result = {{(XLEN-1){1'b0}}, slt_res};
            3'b011:  result = {{(XLEN-1){1'b0}}, sltu_res};
            default: result = alu_q;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StEmpty;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            ptr_q       <= 1'b1;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (gnt_any) begin
                        state_q     <= StFull;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StFull: begin
                    if (rsp_ready && !gnt_any) begin
                        state_q     <= StEmpty;
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
            if (gnt_any) begin
                rsp_data_q <= result;
                rsp_id_q   <= gnt_id;
                ptr_q      <= gnt_id;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_q     = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_ladybird_alu_arbiter.sv
// Directed and random checks of ladybird_alu_arbiter against a transaction-level model
// (grant rule, held result, owner id) with an ALU model closing the loop on alu_q.

module tb_ladybird_alu_arbiter;

    logic             clk;
    logic             nrst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_op;
    logic [1:0]       req_alt;
    logic [1:0][31:0] req_src1;
    logic [1:0][31:0] req_src2;
    logic [2:0]       alu_operation;
    logic             alu_alternate;
    logic [31:0]      alu_src1;
    logic [31:0]      alu_src2;
    logic [31:0]      alu_q;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_q;
    logic             rsp_id;
    logic             junk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: is a result held, its value/owner, and who was granted last.
    bit        m_full;
    bit [31:0] m_q;
    bit        m_id;
    bit        m_last;

    ladybird_alu_arbiter dut (
        .clk           (clk),
        .nrst          (nrst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_alt       (req_alt),
        .req_src1      (req_src1),
        .req_src2      (req_src2),
        .alu_operation (alu_operation),
        .alu_alternate (alu_alternate),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .alu_q         (alu_q),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_q         (rsp_q),
        .rsp_id        (rsp_id)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_q = junk ? 32'hDEAD_BEEF : alu_ref(alu_operation, alu_alternate, alu_src1, alu_src2);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setr(input int i, input logic [2:0] op, input logic alt,
                        input logic [31:0] a, input logic [31:0] b);
        req_op[i]   = op;
        req_alt[i]  = alt;
        req_src1[i] = a;
        req_src2[i] = b;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_q    = '0;
        m_id   = 1'b0;
        m_last = 1'b1;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic cycle();
        logic [1:0]  er;
        logic        g;
        logic [31:0] res;
        #2;
        er = 2'b00;
        g  = 1'b0;
        if (nrst && (!m_full || rsp_ready) && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = ~m_last;
            else                    g = req_valid[1];
            er[g] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(er));
        if (er != 2'b00) begin
            chk("alu_op", 32'(alu_operation), 32'(req_op[g]));
            chk("alu_alt", 32'(alu_alternate), 32'(req_alt[g]));
            chk("alu_src1", alu_src1, req_src1[g]);
            chk("alu_src2", alu_src2, req_src2[g]);
        end else begin
            chk("alu_idle_op", 32'({alu_operation, alu_alternate}), 32'd0);
            chk("alu_idle_src", alu_src1 | alu_src2, 32'd0);
        end
        if (req_op[g] == 3'd2)
            res = ($signed(req_src1[g]) < $signed(req_src2[g])) ? 32'd1 : 32'd0;
        else if (req_op[g] == 3'd3)
            res = (req_src1[g] < req_src2[g]) ? 32'd1 : 32'd0;
        else
            res = junk ? 32'hDEAD_BEEF : alu_ref(req_op[g], req_alt[g], req_src1[g], req_src2[g]);
        @(posedge clk);
        if (er != 2'b00) begin
            m_full = 1'b1;
            m_q    = res;
            m_id   = g;
            m_last = g;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            chk("rsp_q", rsp_q, m_q);
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
    endtask

    initial begin
        nrst      = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        junk      = 1'b0;
        setr(0, 3'd0, 1'b0, 32'd1, 32'd2);
        setr(1, 3'd0, 1'b0, 32'd3, 32'd4);
        model_reset();
        #1 nrst = 1'b0;
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_q", rsp_q, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 nrst = 1'b1;

        // Single add from requester 0.
        req_valid = 2'b01;
        setr(0, 3'd0, 1'b0, 32'd5, 32'd7);
        cycle();
        chk("add_q", rsp_q, 32'd12);
        chk("add_id", 32'(rsp_id), 32'd0);

        // Backpressure with both requesters waiting.
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        setr(1, 3'd6, 1'b0, 32'h0F00, 32'h00F0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("bp_hold", rsp_q, 32'h0000_000C);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("bp_b2b_valid", 32'(rsp_valid), 32'd1);
        chk("bp_b2b_q", rsp_q, 32'h0000_0FF0);

        // Set-less-than with the ALU result poisoned.
        req_valid = 2'b10;
        junk      = 1'b1;
        setr(1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("slt", rsp_q, 32'd1);
        setr(1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
        cycle();
        chk("sltu", rsp_q, 32'd0);
        junk = 1'b0;

        // Arithmetic shift right via the alternate flag.
        req_valid = 2'b01;
        setr(0, 3'd5, 1'b1, 32'h8000_0000, 32'd4);
        cycle();
        chk("sra", rsp_q, 32'hF800_0000);

        // Reset while a result is held, then contention.
        setr(0, 3'd0, 1'b0, 32'h1234, 32'd0);
        cycle();
        chk("pre_rst_q", rsp_q, 32'h1234);
        req_valid = 2'b11;
        nrst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_q", rsp_q, 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        nrst = 1'b1;
        setr(1, 3'd4, 1'b0, 32'hA5A5_A5A5, 32'hFFFF_0000);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("contend_id", 32'(rsp_id), 32'(i % 2));
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            junk      = ($urandom_range(0, 4) == 0);
            for (int r = 0; r < 2; r++) begin
                setr(r, 3'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ladybird_alu_arbiter.md
LADYBIRD_ALU_ARBITER -- requirements
Module: ladybird_alu_arbiter

Interface
REQ-001 SHALL take parameter XLEN from ladybird_config, fixed at 32; meaning: datapath width.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-003 SHALL have port nrst, input, 1 bit; reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, [1:0]; requester i presents an operation.
REQ-005 SHALL have port req_ready, output, [1:0]; requester i's operation is accepted this cycle.
REQ-006 SHALL have port req_op, input, [1:0][2:0]; ALU operation code per requester.
REQ-007 SHALL have port req_alt, input, [1:0]; sub/sra alternate flag per requester.
REQ-008 SHALL have port req_src1 and port req_src2, input, [1:0][XLEN-1:0]; operands per requester.
REQ-009 SHALL have port alu_operation (output, 3 bits), alu_alternate (output, 1 bit), alu_src1 and alu_src2 (output, XLEN each); these drive the shared combinational ALU.
REQ-010 SHALL have port alu_q, input, XLEN; ALU result, same cycle.
REQ-011 SHALL have port rsp_valid, output, 1 bit; a result is held.
REQ-012 SHALL have port rsp_ready, input, 1 bit; the consumer takes the result.
REQ-013 SHALL have port rsp_q, output, XLEN; the held result.
REQ-014 SHALL have port rsp_id, output, 1 bit; index of the requester that owns rsp_q.

Function
REQ-015 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a rising edge; the response transfer rule is the same, using rsp_valid and rsp_ready.
REQ-016 The output register SHALL use a two-state FSM:
- EMPTY: rsp_valid=0.
- FULL: rsp_valid=1.
- EMPTY->FULL on grant.
- FULL->EMPTY on rsp_ready with no grant.
- FULL stays FULL on rsp_ready with a grant (back-to-back) or on no rsp_ready.
REQ-017 Grant SHALL be allowed when the state is EMPTY, or when it is FULL and rsp_ready=1.
REQ-018 At most one req_ready bit SHALL be high per cycle.
REQ-019 req_ready SHALL be 0 for any requester whose req_valid is 0.
REQ-020 Arbitration SHALL be round-robin:
- A 1-bit last-grant pointer gives priority to the other requester.
- With a single requester valid, that requester SHALL be granted regardless of the pointer.
- The pointer SHALL update only on a grant.
REQ-021 The alu_* outputs SHALL be driven combinationally from the granted requester.
REQ-022 When no requester is granted, the alu_* outputs SHALL be all zero.
REQ-023 Latency SHALL be one cycle: the granted result appears on rsp_q the cycle after acceptance, with rsp_id set to the granted requester index.
REQ-024 For ops 000/001/100/101/110/111 the captured result SHALL be alu_q.
REQ-025 For op 010 (SLT) the captured result SHALL be {31'b0, signed(src1) < signed(src2)}, computed locally; alu_q SHALL be ignored.
REQ-026 For op 011 (SLTU) the captured result SHALL be {31'b0, src1 < src2 unsigned}, computed locally; alu_q SHALL be ignored.
REQ-027 rsp_q and rsp_id SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-028 When both requesters are valid and the register is FULL with rsp_ready=0, neither requester SHALL be granted and the pointer SHALL be unchanged.
REQ-029 req_ready SHALL depend combinationally on req_valid, the pointer, the FSM state and rsp_ready only; it SHALL NOT depend on operands.

Reset
REQ-030 On nrst low, asynchronously:
- the FSM SHALL enter EMPTY;
- rsp_valid, rsp_q and rsp_id SHALL be 0;
- the pointer SHALL be 1, so requester 0 has first priority.
REQ-031 While nrst is low, req_ready SHALL be 0.
REQ-032 An in-flight held result SHALL be discarded on reset, and no response SHALL be issued for it.
REQ-033 Operation SHALL resume on the first rising edge after nrst deasserts.

Verification
REQ-034 Single add: req0 valid with op=000, alt=0, src1=5, src2=7, rsp_ready=1 -> req_ready=01 that cycle; the next cycle rsp_valid=1, rsp_q=12, rsp_id=0.
REQ-035 Contention: both requesters held valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1 and rsp_id follows 0,1,0,1 one cycle later.
REQ-036 Backpressure: rsp_ready=0 with the register FULL holding 0x0000000C and both requesters valid -> req_ready=00 and rsp_q stable for 4 cycles; when rsp_ready rises, same-cycle grant and back-to-back rsp_valid.
REQ-037 Set-less-than:
- SLT with src1=0xFFFFFFFF, src2=1 -> rsp_q=1.
- SLTU with the same operands -> rsp_q=0.
- alu_q forced to 0xDEADBEEF in both cases -> ignored.
REQ-038 Alternate forwarding: op=101, alt=1, src1=0x80000000, src2=4 -> alu_alternate=1, and rsp_q equals the bench ALU model output 0xF8000000.
REQ-039 Reset mid-operation: FULL with rsp_q=0x1234 and nrst pulsed low between clock edges -> rsp_valid=0 and rsp_q=0 immediately; the first grant afterwards goes to requester 0 when both are valid.
